// File: rtl/delay_count_timer.sv
// Serial-loaded delay timer: shifts in a DELAY_W-bit delay, counts (delay+1) units, holds done until ack.
// Define TIMER_ABORT_EN to add an abort input that drops any active phase back to IDLE with a rearm pulse.
//
// state | meaning
// IDLE  | waiting for start_shifting (ignored while rearm is high)
// SHIFT | assembling the delay value, MSB first
// COUNT | counting down delay units, TICKS_PER_UNIT cycles each
// DONE  | timer expired, waiting for ack
module delay_count_timer #(
  parameter int DELAY_W        = 4,
  parameter int TICKS_PER_UNIT = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_shifting,
  input  logic               data,
  input  logic               ack,
`ifdef TIMER_ABORT_EN
  input  logic               abort,
`endif
  output logic               counting,
  output logic [DELAY_W-1:0] count,
  output logic               done,
  output logic               rearm
);

  localparam int TICK_W = $clog2(TICKS_PER_UNIT);
  localparam int BIT_W  = $clog2(DELAY_W + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DELAY_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COUNT, DONE} state_t;

  state_t              state;
  logic [DELAY_W-1:0]  delay_reg;
  logic [DELAY_W-1:0]  shifted;
  logic [BIT_W-1:0]    bitcnt;
  logic [TICK_W-1:0]   tick;
  logic                abort_req;

`ifdef TIMER_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign shifted = {delay_reg[DELAY_W-2:0], data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      delay_reg <= '0;
      bitcnt    <= '0;
      tick      <= '0;
      counting  <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
      rearm     <= 1'b0;
    end else begin
      rearm <= 1'b0;
      if (abort_req) begin
        state    <= IDLE;
        bitcnt   <= '0;
        tick     <= '0;
        counting <= 1'b0;
        count    <= '0;
        done     <= 1'b0;
        rearm    <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            // rearm high means the recognizer is still being reset; its level is stale
            if (start_shifting && !rearm) begin
              delay_reg <= {{(DELAY_W-1){1'b0}}, data};
              bitcnt    <= BIT_W'(1);
              state     <= SHIFT;
            end
          end
          SHIFT: begin
            delay_reg <= shifted;
            bitcnt    <= bitcnt + BIT_W'(1);
            if (bitcnt == BIT_LAST) begin
              state    <= COUNT;
              count    <= shifted;
              tick     <= '0;
              counting <= 1'b1;
            end
          end
          COUNT: begin
            if (tick == TICK_LAST) begin
              tick <= '0;
              if (count != '0) begin
                count <= count - DELAY_W'(1);
              end else begin
                state    <= DONE;
                counting <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
          DONE: begin
            if (ack) begin
              state <= IDLE;
              done  <= 1'b0;
              rearm <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delay_count_timer.sv
// Bench for delay_count_timer with TICKS_PER_UNIT=4: randomized delays checked against an arithmetic timing model.
module tb_delay_count_timer;

  localparam int DW  = 4;
  localparam int TPU = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_shifting;
  logic          data;
  logic          ack;
`ifdef TIMER_ABORT_EN
  logic          abort;
`endif
  logic          counting;
  logic [DW-1:0] count;
  logic          done;
  logic          rearm;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  delay_count_timer #(.DELAY_W(DW), .TICKS_PER_UNIT(TPU)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_shifting (start_shifting),
    .data           (data),
    .ack            (ack),
`ifdef TIMER_ABORT_EN
    .abort          (abort),
`endif
    .counting       (counting),
    .count          (count),
    .done           (done),
    .rearm          (rearm)
  );

  // Expected remaining units at the k-th COUNT cycle: each unit lasts TPU cycles.
  function automatic logic [DW-1:0] model_count(input int d, input int k);
    return DW'(d - k / TPU);
  endfunction

  // Called at a negedge; drives the delay MSB first, one bit per cycle, ends at the first COUNT sample.
  task automatic shift_in(input string lbl, input logic [DW-1:0] d, input bit ack_noise);
    start_shifting = 1'b1;
    for (int i = DW - 1; i >= 0; i--) begin
      data = d[i];
      if (ack_noise) ack = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if ((i != 0 && counting !== 1'b0) || done !== 1'b0 || rearm !== 1'b0)
        $display("FAIL %s shift bit=%0d counting=%0b done=%0b rearm=%0b required counting=%0b done=0 rearm=0",
                 lbl, i, counting, done, rearm, (i == 0));
      else n_pass++;
    end
  endtask

  task automatic count_phase(input string lbl, input int d, input bit ack_noise);
    for (int k = 0; k < (d + 1) * TPU; k++) begin
      n_checks++;
      if (counting !== 1'b1 || count !== model_count(d, k) || done !== 1'b0)
        $display("FAIL %s count k=%0d counting=%0b count=%0d done=%0b required counting=1 count=%0d done=0",
                 lbl, k, counting, count, done, model_count(d, k));
      else n_pass++;
      data = 1'($urandom);
      ack  = ack_noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    ack = 1'b0;
    n_checks++;
    if (counting !== 1'b0 || done !== 1'b1 || count !== '0)
      $display("FAIL %s expiry counting=%0b done=%0b count=%0d required counting=0 done=1 count=0",
               lbl, counting, done, count);
    else n_pass++;
  endtask

  task automatic do_ack(input string lbl);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) $display("FAIL %s done_hold done=%0b required 1", lbl, done);
    else n_pass++;
    ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || rearm !== 1'b1)
      $display("FAIL %s ack done=%0b rearm=%0b required done=0 rearm=1", lbl, done, rearm);
    else n_pass++;
    ack = 1'b0;
    start_shifting = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rearm !== 1'b0 || done !== 1'b0 || counting !== 1'b0)
      $display("FAIL %s post_ack rearm=%0b done=%0b counting=%0b required all 0", lbl, rearm, done, counting);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start_shifting = 1'b0; data = 1'b0; ack = 1'b0;
`ifdef TIMER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (counting !== 1'b0 || count !== '0 || done !== 1'b0 || rearm !== 1'b0)
      $display("FAIL reset_state counting=%0b count=%0d done=%0b rearm=%0b required all 0",
               counting, count, done, rearm);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    shift_in("reset_mid", 4'd9, 1'b0);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (counting !== 1'b0 || count !== '0 || done !== 1'b0 || rearm !== 1'b0)
      $display("FAIL reset_async counting=%0b count=%0d done=%0b rearm=%0b required all 0",
               counting, count, done, rearm);
    else n_pass++;
    start_shifting = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (counting !== 1'b0 || count !== '0 || done !== 1'b0 || rearm !== 1'b0)
      $display("FAIL reset_idle counting=%0b count=%0d done=%0b rearm=%0b required all 0",
               counting, count, done, rearm);
    else n_pass++;
    shift_in("after_reset", 4'd3, 1'b0);
    count_phase("after_reset", 3, 1'b0);
    do_ack("after_reset");
  endtask

  task automatic test_timing;
    shift_in("timing", 4'b0010, 1'b0);
    count_phase("timing", 2, 1'b0);
    do_ack("timing");
  endtask

  task automatic test_boundaries;
    shift_in("delay0", 4'h0, 1'b0);
    count_phase("delay0", 0, 1'b0);
    do_ack("delay0");
    shift_in("delayF", 4'hF, 1'b0);
    count_phase("delayF", 15, 1'b0);
    do_ack("delayF");
  endtask

  task automatic test_handshake;
    logic [DW-1:0] d_next;
    d_next = DW'($urandom_range(1, 15));
    shift_in("handshake", 4'd1, 1'b0);
    count_phase("handshake", 1, 1'b0);
    ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rearm !== 1'b1 || done !== 1'b0)
      $display("FAIL handshake_ack1 rearm=%0b done=%0b required rearm=1 done=0", rearm, done);
    else n_pass++;
    data = ~d_next[DW-1];
    @(negedge clk);
    n_checks++;
    if (rearm !== 1'b0 || done !== 1'b0 || counting !== 1'b0)
      $display("FAIL handshake_ack2 rearm=%0b done=%0b counting=%0b required all 0", rearm, done, counting);
    else n_pass++;
    // ack still high for a third cycle while the retrigger begins
    shift_in("retrigger", d_next, 1'b0);
    count_phase("retrigger", int'(d_next), 1'b0);
    do_ack("retrigger");
  endtask

  task automatic test_ack_misuse;
    shift_in("ack_misuse", 4'b0010, 1'b1);
    count_phase("ack_misuse", 2, 1'b1);
    do_ack("ack_misuse");
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      logic [DW-1:0] d;
      bit noise;
      d = DW'($urandom_range(0, 15));
      noise = 1'($urandom);
      shift_in("random", d, noise);
      count_phase("random", int'(d), noise);
      do_ack("random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

`ifdef TIMER_ABORT_EN
  task automatic test_abort;
    shift_in("abort", 4'd5, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    n_checks++;
    if (counting !== 1'b0 || done !== 1'b0 || count !== '0 || rearm !== 1'b1)
      $display("FAIL abort_count counting=%0b done=%0b count=%0d rearm=%0b required 0 0 0 1",
               counting, done, count, rearm);
    else n_pass++;
    abort = 1'b0;
    start_shifting = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rearm !== 1'b0 || counting !== 1'b0)
      $display("FAIL abort_post rearm=%0b counting=%0b required 0 0", rearm, counting);
    else n_pass++;
    shift_in("abort_ack", 4'd1, 1'b0);
    count_phase("abort_ack", 1, 1'b0);
    ack = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rearm !== 1'b1 || done !== 1'b0)
      $display("FAIL abort_ack rearm=%0b done=%0b required rearm=1 done=0", rearm, done);
    else n_pass++;
    start_shifting = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rearm !== 1'b0 || done !== 1'b0 || counting !== 1'b0)
      $display("FAIL abort_ack_single rearm=%0b done=%0b counting=%0b required all 0", rearm, done, counting);
    else n_pass++;
    ack = 1'b0;
    abort = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_boundaries();
    test_handshake();
    test_ack_misuse();
    test_random();
    test_reset_mid();
`ifdef TIMER_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
